qbert_move_ctrl: RTL and testbench

Parametrised successor to the fixed 21-cube Q*bert movement/game-state logic. Tracks the player on a triangular pyramid of ROWS rows in grid coordinates and converts the position to pixel centres for the renderer. Debounces the four diagonal buttons and keeps a visited bitmap of cubes. Runs a game FSM with lives, a timed fall/respawn, win/loss detection and restart, and drives a 7-segment lives digit. Sits between the board buttons and the VGA drawing block on clk_25.

---
 rtl/qbert_pkg.sv | 40 ++++
 rtl/btn_debounce.sv | 40 ++++
 rtl/qbert_move_ctrl.sv | 161 ++++++++++++++++
 tb/tb_qbert_move_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qbert_pkg.sv
// Shared types and constants for the Q*bert movement controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package qbert_pkg;

  typedef enum logic [1:0] {
    PLAY = 2'd0,
    FALL = 2'd1,
    LOST = 2'd2,
    WON  = 2'd3
  } state_t;

  // Button index of each diagonal direction
  localparam int DIR_UR = 0;
  localparam int DIR_DR = 1;
  localparam int DIR_DL = 2;
  localparam int DIR_UL = 3;

  // Active-low segment patterns {a,b,c,d,e,f,g}, entry n shows digit n
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'b0000100,  // 9
    7'b0000000,  // 8
    7'b0001111,  // 7
    7'b0100000,  // 6
    7'b0100100,  // 5
    7'b1001100,  // 4
    7'b0000110,  // 3
    7'b0010010,  // 2
    7'b1001111,  // 1
    7'b0000001   // 0
  };

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] seg_decode(input logic [3:0] val);
    if (val <= 4'd9) return SEG_TABLE[val];
    return SEG_BLANK;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Synchronises one raw active-low button and emits a single press pulse.
// Latency: 2 sync cycles plus DEBOUNCE_CYC stable-low cycles to the pulse.
// Backpressure: none; a held button yields one pulse until it goes high again.
// Ports: clk_25/rst_n clock and async reset, btn_raw raw input, press one-cycle pulse.
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 250000
) (
  input  logic clk_25,
  input  logic rst_n,
  input  logic btn_raw,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);

  logic          sync_1;
  logic          sync_2;
  logic [CW-1:0] low_cnt;

  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      sync_1  <= 1'b1;
      sync_2  <= 1'b1;
      low_cnt <= '0;
      press   <= 1'b0;
    end else begin
      sync_1 <= btn_raw;
      sync_2 <= sync_1;
      press  <= 1'b0;
      if (sync_2) begin
        low_cnt <= '0;
      end else if (low_cnt != CW'(DEBOUNCE_CYC)) begin
        // Counter saturates at DEBOUNCE_CYC so a long hold fires only once
        low_cnt <= low_cnt + 1'b1;
        if (low_cnt == CW'(DEBOUNCE_CYC - 1)) press <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/qbert_move_ctrl.sv
// Player position, visited bitmap, lives and game FSM for a ROWS-row pyramid.
// Latency: 1 cycle from debounced press pulse to row/col/pos/visited update.
// Backpressure: none; at most one move per cycle, extra simultaneous pulses dropped.
// Ports: clk_25, rst_n; btn[3:0] (UR,DR,DL,UL) and restart raw active-low;
//        pos_x/pos_y pixel centre, visited bitmap, lives, seg7 digit, falling/lost/won.
module qbert_move_ctrl #(
  parameter int ROWS         = 6,
  parameter int LIVES_INIT   = 5,
  parameter int DEBOUNCE_CYC = 250000,
  parameter int RESPAWN_CYC  = 12500000,
  parameter int X0           = 464,
  parameter int Y0           = 120,
  parameter int STEP_X       = 20,
  parameter int STEP_Y       = 40
) (
  input  logic                          clk_25,
  input  logic                          rst_n,
  input  logic [3:0]                    btn,
  input  logic                          restart,
  output logic [9:0]                    pos_x,
  output logic [9:0]                    pos_y,
  output logic [ROWS*(ROWS+1)/2-1:0]    visited,
  output logic [3:0]                    lives,
  output logic [6:0]                    seg7,
  output logic                          falling,
  output logic                          lost,
  output logic                          won
);

  import qbert_pkg::*;

  localparam int NCUBE = ROWS * (ROWS + 1) / 2;
  localparam int RW    = $clog2(RESPAWN_CYC + 1);

  localparam logic [9:0]       X0_PIX   = X0[9:0];
  localparam logic [9:0]       Y0_PIX   = Y0[9:0];
  localparam logic [3:0]       LIVES_RST = LIVES_INIT[3:0];
  localparam logic [NCUBE-1:0] VIS_RST  = NCUBE'(1);

  logic [4:0]       raw_in;
  logic [4:0]       pulse;
  state_t           state;
  logic [2:0]       row;
  logic [2:0]       col;
  logic [RW-1:0]    resp_cnt;

  int               tr;
  int               tc;
  int               px;
  int               py;
  int               idx;
  logic             mv_vld;
  logic             legal;
  logic [NCUBE-1:0] set_mask;

  assign raw_in = {restart, btn};

  for (genvar i = 0; i < 5; i++) begin : g_deb
    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb (
      .clk_25 (clk_25),
      .rst_n  (rst_n),
      .btn_raw(raw_in[i]),
      .press  (pulse[i])
    );
  end

  // Target cube of the highest-priority pulse; lower-priority pulses are dropped
  always_comb begin
    mv_vld = 1'b1;
    tr     = int'(row);
    tc     = int'(col);
    if (pulse[DIR_UR]) begin
      tr = int'(row) - 1;
    end else if (pulse[DIR_DR]) begin
      tr = int'(row) + 1;
      tc = int'(col) + 1;
    end else if (pulse[DIR_DL]) begin
      tr = int'(row) + 1;
    end else if (pulse[DIR_UL]) begin
      tr = int'(row) - 1;
      tc = int'(col) - 1;
    end else begin
      mv_vld = 1'b0;
    end
    legal = (tr >= 0) && (tr < ROWS) && (tc >= 0) && (tc <= tr);
    px    = X0 + STEP_X * (2 * tc - tr);
    py    = Y0 + STEP_Y * tr;
    idx   = tr * (tr + 1) / 2 + tc;
    set_mask = '0;
    for (int i = 0; i < NCUBE; i++) begin
      if (legal && (i == idx)) set_mask[i] = 1'b1;
    end
  end

  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      state    <= PLAY;
      row      <= '0;
      col      <= '0;
      pos_x    <= X0_PIX;
      pos_y    <= Y0_PIX;
      visited  <= VIS_RST;
      lives    <= LIVES_RST;
      resp_cnt <= '0;
    end else begin
      case (state)
        PLAY: begin
          if (&visited) begin
            state <= WON;
          end else if (mv_vld) begin
            if (legal) begin
              row     <= tr[2:0];
              col     <= tc[2:0];
              pos_x   <= px[9:0];
              pos_y   <= py[9:0];
              visited <= visited | set_mask;
            end else if (lives > 4'd1) begin
              lives    <= lives - 4'd1;
              resp_cnt <= RW'(RESPAWN_CYC - 1);
              state    <= FALL;
            end else begin
              lives <= 4'd0;
              state <= LOST;
            end
          end
        end
        FALL: begin
          if (resp_cnt == '0) begin
            row        <= '0;
            col        <= '0;
            pos_x      <= X0_PIX;
            pos_y      <= Y0_PIX;
            visited[0] <= 1'b1;
            state      <= (&visited) ? WON : PLAY;
          end else begin
            resp_cnt <= resp_cnt - 1'b1;
          end
        end
        default: begin
          // LOST and WON hold everything until a restart press
          if (pulse[4]) begin
            state    <= PLAY;
            row      <= '0;
            col      <= '0;
            pos_x    <= X0_PIX;
            pos_y    <= Y0_PIX;
            visited  <= VIS_RST;
            lives    <= LIVES_RST;
            resp_cnt <= '0;
          end
        end
      endcase
    end
  end

  assign falling = (state == FALL);
  assign lost    = (state == LOST);
  assign won     = (state == WON);
  assign seg7    = seg_decode(lives);

endmodule

// File: tb/tb_qbert_move_ctrl.sv
// Scoreboard bench for qbert_move_ctrl on a 3-row pyramid with short debounce/respawn.
// Latency: n/a.
// Backpressure: n/a.
module tb_qbert_move_ctrl;

  localparam int ROWS = 3;
  localparam int NC = 6;
  localparam int LIV = 3;
  localparam int X0 = 464;
  localparam int Y0 = 120;
  localparam int SX = 20;
  localparam int SY = 40;

  typedef struct packed {
    logic [9:0]    x;
    logic [9:0]    y;
    logic [NC-1:0] vis;
    logic [3:0]    lives;
    logic [6:0]    seg;
    logic          fall;
    logic          lost;
    logic          won;
  } snap_t;

  typedef enum int {M_PLAY, M_LOST, M_WON} mstate_t;

  logic          clk_25 = 1'b0;
  logic          rst_n = 1'b0;
  logic [3:0]    btn = 4'hF;
  logic          restart = 1'b1;
  logic [9:0]    pos_x;
  logic [9:0]    pos_y;
  logic [NC-1:0] visited;
  logic [3:0]    lives;
  logic [6:0]    seg7;
  logic          falling;
  logic          lost;
  logic          won;

  int checks = 0;
  int errors = 0;
  snap_t exp_q[$];
  bit mon_en = 1'b0;
  snap_t prev;

  // Reference model state
  int      m_r, m_c, m_lives;
  bit      m_fall;
  bit      m_vis[ROWS][ROWS];
  mstate_t m_state;

  qbert_move_ctrl #(
    .ROWS(ROWS), .LIVES_INIT(LIV), .DEBOUNCE_CYC(4), .RESPAWN_CYC(8),
    .X0(X0), .Y0(Y0), .STEP_X(SX), .STEP_Y(SY)
  ) dut (
    .clk_25(clk_25), .rst_n(rst_n), .btn(btn), .restart(restart),
    .pos_x(pos_x), .pos_y(pos_y), .visited(visited), .lives(lives),
    .seg7(seg7), .falling(falling), .lost(lost), .won(won)
  );

  always #20 clk_25 = ~clk_25;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [6:0] seg_of(input int v);
    case (v)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic snap_t dut_snap();
    snap_t s;
    s.x = pos_x; s.y = pos_y; s.vis = visited; s.lives = lives; s.seg = seg7;
    s.fall = falling; s.lost = lost; s.won = won;
    return s;
  endfunction

  function automatic bit all_visited();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c <= r; c++)
        if (!m_vis[r][c]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic snap_t model_snap();
    snap_t s;
    s.x = 10'(X0 + SX * (2 * m_c - m_r));
    s.y = 10'(Y0 + SY * m_r);
    s.vis = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c <= r; c++)
        if (m_vis[r][c]) s.vis = s.vis | (NC'(1) << (r * (r + 1) / 2 + c));
    s.lives = 4'(m_lives);
    s.seg = seg_of(m_lives);
    s.fall = m_fall;
    s.lost = (m_state == M_LOST);
    s.won = (m_state == M_WON);
    return s;
  endfunction

  task automatic model_reset();
    m_r = 0; m_c = 0; m_lives = LIV; m_fall = 1'b0; m_state = M_PLAY;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < ROWS; c++)
        m_vis[r][c] = 1'b0;
    m_vis[0][0] = 1'b1;
  endtask

  // Expected effect of one accepted press event (mask bit 4 = restart)
  task automatic model_press(input logic [4:0] mask);
    int d, tr, tc;
    d = -1;
    for (int i = 3; i >= 0; i--) if (mask[i]) d = i;
    if (m_state == M_PLAY && d >= 0) begin
      case (d)
        0: begin tr = m_r - 1; tc = m_c;     end
        1: begin tr = m_r + 1; tc = m_c + 1; end
        2: begin tr = m_r + 1; tc = m_c;     end
        default: begin tr = m_r - 1; tc = m_c - 1; end
      endcase
      if (tr >= 0 && tr < ROWS && tc >= 0 && tc <= tr) begin
        m_r = tr; m_c = tc; m_vis[tr][tc] = 1'b1;
        exp_q.push_back(model_snap());
        if (all_visited()) begin
          m_state = M_WON;
          exp_q.push_back(model_snap());
        end
      end else if (m_lives > 1) begin
        m_lives--; m_fall = 1'b1;
        exp_q.push_back(model_snap());
        m_fall = 1'b0; m_r = 0; m_c = 0;
        exp_q.push_back(model_snap());
      end else begin
        m_lives = 0; m_state = M_LOST;
        exp_q.push_back(model_snap());
      end
    end else if ((m_state == M_LOST || m_state == M_WON) && mask[4]) begin
      model_reset();
      exp_q.push_back(model_snap());
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Monitor: every change of the output bundle must match the next expected snapshot
  always @(negedge clk_25) begin
    if (mon_en) begin
      snap_t cur;
      cur = dut_snap();
      if (cur !== prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change: got %h was %h", cur, prev);
        end else begin
          snap_t e;
          e = exp_q.pop_front();
          if (cur !== e) begin
            errors++;
            $display("FAIL scoreboard: got %h expected %h", cur, e);
          end
        end
        prev = cur;
      end
    end
  end

  task automatic hold(input logic [4:0] mask, input int cyc);
    @(posedge clk_25); #1;
    btn = ~mask[3:0]; restart = ~mask[4];
    repeat (cyc) @(posedge clk_25);
    #1;
    btn = 4'hF; restart = 1'b1;
  endtask

  task automatic settle(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk_25);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL settle: %0d expected changes not seen", exp_q.size());
      exp_q.delete();
    end
    repeat (6) @(posedge clk_25);
  endtask

  task automatic press(input logic [4:0] mask);
    model_press(mask);
    hold(mask, 6);
    settle(60);
  endtask

  initial begin
    int n;
    logic [4:0] m;
    model_reset();
    repeat (3) @(posedge clk_25);
    #1 rst_n = 1'b1;
    @(negedge clk_25);
    prev = dut_snap();
    mon_en = 1'b1;
    chk("reset_snap", 64'(dut_snap()), 64'(model_snap()));
    chk("reset_seg7", 64'(seg7), 64'(7'b0000110));
    chk("reset_pos_x", 64'(pos_x), 64'd464);

    // single down-right move, then a short glitch that must not move
    press(5'b00010);
    chk("dr_pos_x", 64'(pos_x), 64'd484);
    chk("dr_pos_y", 64'(pos_y), 64'd160);
    chk("dr_visited", 64'(visited), 64'(6'b000101));
    hold(5'b00010, 3);
    settle(20);

    // back to top, then fall off the top
    press(5'b01000);
    press(5'b00001);
    chk("fall_lives", 64'(lives), 64'd2);
    chk("fall_pos_x", 64'(pos_x), 64'd464);
    chk("fall_done", 64'(falling), 64'd0);

    // simultaneous down-right and down-left: down-right wins
    press(5'b00110);
    chk("prio_pos_x", 64'(pos_x), 64'd484);

    // finish the board: (2,2) (1,1) (2,1) (1,0) (2,0)
    press(5'b00010);
    press(5'b01000);
    press(5'b00100);
    press(5'b01000);
    press(5'b00100);
    chk("won", 64'(won), 64'd1);
    press(5'b00001);
    press(5'b10000);
    chk("restart_vis", 64'(visited), 64'd1);
    chk("restart_lives", 64'(lives), 64'd3);
    chk("restart_won", 64'(won), 64'd0);

    // restart ignored while playing; three falls lose the game
    press(5'b10000);
    press(5'b00001);
    press(5'b00001);
    press(5'b00001);
    chk("lost", 64'(lost), 64'd1);
    chk("lost_seg7", 64'(seg7), 64'(7'b0000001));
    chk("lost_lives", 64'(lives), 64'd0);
    press(5'b10000);

    // asynchronous reset in the middle of a fall
    model_press(5'b00001);
    hold(5'b00001, 6);
    n = 0;
    while (exp_q.size() > 1 && n < 40) begin @(posedge clk_25); n++; end
    chk("fall_entered", 64'(exp_q.size()), 64'd1);
    repeat (3) @(posedge clk_25);
    #1;
    exp_q.delete();
    model_reset();
    exp_q.push_back(model_snap());
    rst_n = 1'b0;
    #1;
    chk("midfall_reset", 64'(dut_snap()), 64'(model_snap()));
    repeat (2) @(posedge clk_25);
    #1 rst_n = 1'b1;
    settle(20);

    // randomized play with glitches and multi-button presses
    for (int k = 0; k < 70; k++) begin
      if ((m_state != M_PLAY) && ($urandom_range(0, 1) == 1)) begin
        press(5'b10000);
      end else begin
        case ($urandom_range(0, 4))
          0, 1, 2: press(5'(1 << $urandom_range(0, 3)));
          3: begin
            m = 5'($urandom_range(1, 31));
            press(m);
          end
          default: begin
            m = 5'($urandom_range(1, 31));
            hold(m, $urandom_range(1, 3));
            settle(20);
          end
        endcase
      end
    end
    chk("final_snap", 64'(dut_snap()), 64'(model_snap()));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
